// File: rtl/blake2_msg_sched.sv
// BLAKE2 message scheduler: cuts an incoming byte stream into BB-byte blocks,
// zero-pads the final block, loads the compression core one byte per cycle,
// holds off while the core compresses and forwards the digest stream.
// Optional build macro BLAKE2_SCHED_STATS_EN adds block / message counters.
//
// state    | meaning
// IDLE     | no message in flight; first accepted byte starts block 0
// LOAD     | passing message bytes straight through to the core
// PAD      | emitting zero bytes up to the end of the final block
// WAIT_F   | core compressing a non-final block; input stalled
// WAIT_RES | final block loaded; waiting for the core's done pulse
// OUT      | forwarding nn digest bytes, one per cycle
module blake2_msg_sched #(
    parameter int BB    = 128,
    parameter int LL_W  = 128,
    parameter int F_LAT = 106
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [7:0]              cfg_kk_i,
    input  logic [7:0]              cfg_nn_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [7:0]              s_data_i,
    input  logic                    s_last_i,
    output logic [7:0]              core_kk_o,
    output logic [7:0]              core_nn_o,
    output logic [LL_W-1:0]         core_ll_o,
    output logic                    core_block_first_o,
    output logic                    core_block_last_o,
    output logic                    core_data_v_o,
    output logic [$clog2(BB)-1:0]   core_data_idx_o,
    output logic [7:0]              core_data_o,
    input  logic                    core_done_i,
    input  logic [7:0]              core_h_i,
    output logic                    h_valid_o,
    output logic [7:0]              h_data_o,
    output logic                    h_last_o,
`ifdef BLAKE2_SCHED_STATS_EN
    output logic [31:0]             stat_blocks_o,
    output logic [31:0]             stat_msgs_o,
`endif
    output logic                    busy_o
);

    localparam int IDX_W = $clog2(BB);
    localparam int CNT_W = (F_LAT > 1) ? $clog2(F_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BB - 1);
    // WAIT_F lasts exactly F_LAT cycles: load F_LAT-1, leave on terminal count 0
    localparam logic [CNT_W-1:0] F_LOAD   = CNT_W'(F_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_WAIT_F,
        ST_WAIT_RES,
        ST_OUT
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  fcnt_q;
    logic [7:0]        ocnt_q;
    logic [7:0]        kk_q;
    logic [7:0]        nn_q;
    logic              first_q;
    logic              last_q;
    logic [LL_W-1:0]   ll_q;
    logic              h_valid_q;
    logic [7:0]        h_data_q;
    logic              h_last_q;

    logic              accept;
    logic [IDX_W-1:0]  cur_idx;
    logic              out_last;

    // byte acceptance and the core-facing view; message bytes reach the core in the accept cycle
    always_comb begin
        s_ready_o          = (state == ST_IDLE) || (state == ST_LOAD);
        accept             = s_valid_i && s_ready_o;
        cur_idx            = (state == ST_IDLE) ? '0 : idx_q;
        out_last           = (ocnt_q == (nn_q - 8'd1));
        core_data_v_o      = accept || (state == ST_PAD);
        core_data_o        = accept ? s_data_i : 8'h00;
        core_data_idx_o    = core_data_v_o ? cur_idx : '0;
        core_block_first_o = (state == ST_IDLE) ? accept : first_q;
        core_block_last_o  = last_q || (accept && s_last_i);
        core_ll_o          = ll_q + LL_W'(accept);
        core_kk_o          = ((state == ST_IDLE) && accept) ? cfg_kk_i : kk_q;
        core_nn_o          = ((state == ST_IDLE) && accept) ? cfg_nn_i : nn_q;
        busy_o             = (state != ST_IDLE);
    end

    assign h_valid_o = h_valid_q;
    assign h_data_o  = h_data_q;
    assign h_last_o  = h_last_q;

    // sequencer: block cutting, padding, compression pacing and digest forwarding
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            idx_q     <= '0;
            fcnt_q    <= '0;
            ocnt_q    <= '0;
            kk_q      <= '0;
            nn_q      <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            ll_q      <= '0;
            h_valid_q <= 1'b0;
            h_data_q  <= '0;
            h_last_q  <= 1'b0;
        end else begin
            h_valid_q <= 1'b0;
            h_last_q  <= 1'b0;
            unique case (state)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        if (state == ST_IDLE) begin
                            kk_q    <= cfg_kk_i;
                            nn_q    <= cfg_nn_i;
                            first_q <= 1'b1;
                        end
                        ll_q <= ll_q + 1'b1;
                        if (s_last_i) begin
                            last_q <= 1'b1;
                        end
                        if (cur_idx == IDX_LAST) begin
                            state  <= s_last_i ? ST_WAIT_RES : ST_WAIT_F;
                            fcnt_q <= F_LOAD;
                        end else begin
                            state <= s_last_i ? ST_PAD : ST_LOAD;
                            idx_q <= cur_idx + 1'b1;
                        end
                    end
                end
                ST_PAD: begin
                    if (idx_q == IDX_LAST) begin
                        state <= ST_WAIT_RES;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_WAIT_F: begin
                    if (fcnt_q == '0) begin
                        state   <= ST_LOAD;
                        idx_q   <= '0;
                        first_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - 1'b1;
                    end
                end
                ST_WAIT_RES: begin
                    if (core_done_i) begin
                        state  <= ST_OUT;
                        ocnt_q <= '0;
                    end
                end
                ST_OUT: begin
                    h_valid_q <= 1'b1;
                    h_data_q  <= core_h_i;
                    h_last_q  <= out_last;
                    if (out_last) begin
                        state   <= ST_IDLE;
                        idx_q   <= '0;
                        ll_q    <= '0;
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        ocnt_q <= ocnt_q + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BLAKE2_SCHED_STATS_EN
    logic [31:0] stat_blocks_q;
    logic [31:0] stat_msgs_q;

    // a block counts when its byte BB-1 reaches the core; a message when its last digest byte leaves
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stat_blocks_q <= '0;
            stat_msgs_q   <= '0;
        end else begin
            if (core_data_v_o && (cur_idx == IDX_LAST)) begin
                stat_blocks_q <= stat_blocks_q + 32'd1;
            end
            if (h_valid_q && h_last_q) begin
                stat_msgs_q <= stat_msgs_q + 32'd1;
            end
        end
    end

    assign stat_blocks_o = stat_blocks_q;
    assign stat_msgs_o   = stat_msgs_q;
`endif

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Testbench for blake2_msg_sched: random messages against a block-level model,
// a stand-in compression core, and a queue-based scoreboard monitor.
module tb_blake2_msg_sched;

    localparam int BB    = 128;
    localparam int LL_W  = 128;
    localparam int F_LAT = 106;
    localparam int IDX_W = $clog2(BB);

    logic             clk;
    logic             nreset;
    logic [7:0]       cfg_kk_i;
    logic [7:0]       cfg_nn_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [7:0]       s_data_i;
    logic             s_last_i;
    logic [7:0]       core_kk_o;
    logic [7:0]       core_nn_o;
    logic [LL_W-1:0]  core_ll_o;
    logic             core_block_first_o;
    logic             core_block_last_o;
    logic             core_data_v_o;
    logic [IDX_W-1:0] core_data_idx_o;
    logic [7:0]       core_data_o;
    logic             core_done_i;
    logic [7:0]       core_h_i;
    logic             h_valid_o;
    logic [7:0]       h_data_o;
    logic             h_last_o;
    logic             busy_o;
`ifdef BLAKE2_SCHED_STATS_EN
    logic [31:0]      stat_blocks_o;
    logic [31:0]      stat_msgs_o;
`endif

    logic core_done_m;
    logic core_done_spur;
    assign core_done_i = core_done_m | core_done_spur;

    blake2_msg_sched #(.BB(BB), .LL_W(LL_W), .F_LAT(F_LAT)) dut (
        .clk                (clk),
        .nreset             (nreset),
        .cfg_kk_i           (cfg_kk_i),
        .cfg_nn_i           (cfg_nn_i),
        .s_valid_i          (s_valid_i),
        .s_ready_o          (s_ready_o),
        .s_data_i           (s_data_i),
        .s_last_i           (s_last_i),
        .core_kk_o          (core_kk_o),
        .core_nn_o          (core_nn_o),
        .core_ll_o          (core_ll_o),
        .core_block_first_o (core_block_first_o),
        .core_block_last_o  (core_block_last_o),
        .core_data_v_o      (core_data_v_o),
        .core_data_idx_o    (core_data_idx_o),
        .core_data_o        (core_data_o),
        .core_done_i        (core_done_i),
        .core_h_i           (core_h_i),
        .h_valid_o          (h_valid_o),
        .h_data_o           (h_data_o),
        .h_last_o           (h_last_o),
`ifdef BLAKE2_SCHED_STATS_EN
        .stat_blocks_o      (stat_blocks_o),
        .stat_msgs_o        (stat_msgs_o),
`endif
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       data;
        logic [IDX_W-1:0] idx;
        logic             first;
        logic             last;
        logic [LL_W-1:0]  ll;
        logic [7:0]       kk;
        logic [7:0]       nn;
    } core_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } h_exp_t;

    core_exp_t  core_q[$];
    h_exp_t     h_q[$];
    int         dn_q[$];
    logic [7:0] db_q[$];

    // BLAKE2b-512("abc")
    logic [511:0] abc_dig = 512'hba80a53f981c4d0d_6a2797b69f12f6e9_4c212f14685ac4b7_4b12bb6fdbffa2d1_7d87c5392aab792d_c252d5de4533cc95_18d38aa8dbf1925a_b92386edd4009923;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en    = 1'b0;
    bit core_auto = 1'b0;
    bit core_busy = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s: got no matching event, expected one", nm);
    endtask

    // Expected core traffic follows from the message alone: blocks of BB bytes,
    // zero fill past the end, ll = bytes of the message delivered so far.
    task automatic send_msg(input int len, input int kk, input int nn, input int gap_pct,
                            input bit use_abc, input bit spur, input bit push);
        logic [7:0] msg[$];
        core_exp_t  e;
        h_exp_t     he;
        logic [7:0] d;
        int         nblk;
        int         pos;
        int         t;
        bit         ok;
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) msg.push_back(use_abc ? 8'(8'h61 + i) : 8'($urandom));
        if (push) begin
            nblk = (len + BB - 1) / BB;
            for (int b = 0; b < nblk; b++) begin
                for (int i = 0; i < BB; i++) begin
                    pos     = b * BB + i;
                    e.data  = (pos < len) ? msg[pos] : 8'h00;
                    e.idx   = IDX_W'(i);
                    e.first = (b == 0);
                    e.last  = (b == nblk - 1) && (pos >= len - 1);
                    e.ll    = LL_W'((pos < len) ? pos + 1 : len);
                    e.kk    = 8'(kk);
                    e.nn    = 8'(nn);
                    core_q.push_back(e);
                end
            end
            dn_q.push_back(nn);
            for (int j = 0; j < nn; j++) begin
                d = (use_abc && nn == 64) ? abc_dig[511 - 8*j -: 8] : 8'($urandom);
                db_q.push_back(d);
                he.data = d;
                he.last = (j == nn - 1);
                h_q.push_back(he);
            end
        end
        cfg_kk_i = 8'(kk);
        cfg_nn_i = 8'(nn);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                s_valid_i      = 1'b0;
                s_data_i       = 8'($urandom);
                s_last_i       = 1'($urandom);
                core_done_spur = spur;
                @(posedge clk); #1;
                core_done_spur = 1'b0;
            end
            s_valid_i = 1'b1;
            s_data_i  = msg[i];
            s_last_i  = (i == len - 1);
            t = 0;
            do begin
                @(negedge clk);
                ok = s_ready_o;
                @(posedge clk); #1;
                t++;
            end while (!ok && t < 2000);
            if (!ok) fail_now("accept_timeout");
            if (i == 0) begin
                cfg_kk_i = 8'($urandom);
                cfg_nn_i = 8'($urandom);
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_o || h_q.size() != 0 || core_q.size() != 0 || core_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            fail_now("idle_timeout");
            core_q.delete();
            h_q.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Stand-in compression core: after the final block it pulses done, then streams the digest
    initial begin
        int n;
        core_done_m = 1'b0;
        core_h_i    = 8'h00;
        forever begin
            @(negedge clk);
            if (core_auto && nreset && core_data_v_o && core_block_last_o &&
                core_data_idx_o == IDX_W'(BB - 1)) begin
                if (dn_q.size() == 0) begin
                    fail_now("core_no_digest_queued");
                end else begin
                    core_busy = 1'b1;
                    n = dn_q.pop_front();
                    repeat ($urandom_range(1, 6)) @(posedge clk);
                    #1 core_done_m = 1'b1;
                    @(posedge clk); #1;
                    core_done_m = 1'b0;
                    for (int j = 0; j < n; j++) begin
                        core_h_i = (db_q.size() != 0) ? db_q.pop_front() : 8'h00;
                        @(posedge clk); #1;
                    end
                    core_h_i  = 8'($urandom);
                    core_busy = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every core strobe and digest byte pops one expectation
    initial begin
        bit        meas;
        int        fcount;
        core_exp_t e;
        h_exp_t    he;
        meas   = 1'b0;
        fcount = 0;
        forever begin
            @(negedge clk);
            if (!(mon_en && nreset)) begin
                meas = 1'b0;
            end else begin
                if (meas) begin
                    if (s_ready_o) begin
                        check("wait_f_stall_cycles", 128'(fcount), 128'(F_LAT));
                        meas = 1'b0;
                    end else begin
                        fcount++;
                    end
                end
                if (core_data_v_o) begin
                    if (core_q.size() == 0) begin
                        fail_now("core_unexpected_strobe");
                    end else begin
                        e = core_q.pop_front();
                        check("core_data",  128'(core_data_o),        128'(e.data));
                        check("core_idx",   128'(core_data_idx_o),    128'(e.idx));
                        check("core_first", 128'(core_block_first_o), 128'(e.first));
                        check("core_last",  128'(core_block_last_o),  128'(e.last));
                        check("core_ll",    128'(core_ll_o),          128'(e.ll));
                        check("core_kk",    128'(core_kk_o),          128'(e.kk));
                        check("core_nn",    128'(core_nn_o),          128'(e.nn));
                        if (core_data_idx_o == IDX_W'(BB - 1) && !core_block_last_o) begin
                            meas   = 1'b1;
                            fcount = 0;
                        end
                    end
                end
                if (h_valid_o) begin
                    if (h_q.size() == 0) begin
                        fail_now("h_unexpected_byte");
                    end else begin
                        he = h_q.pop_front();
                        check("h_data", 128'(h_data_o), 128'(he.data));
                        check("h_last", 128'(h_last_o), 128'(he.last));
                    end
                end
            end
        end
    end

    initial begin
        int t;
        bit seen;
        nreset         = 1'b0;
        s_valid_i      = 1'b0;
        s_data_i       = 8'h00;
        s_last_i       = 1'b0;
        cfg_kk_i       = 8'h5a;
        cfg_nn_i       = 8'h20;
        core_done_spur = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        check("rst_s_ready", 128'(s_ready_o),          128'(1));
        check("rst_busy",    128'(busy_o),             128'(0));
        check("rst_h_valid", 128'(h_valid_o),          128'(0));
        check("rst_h_last",  128'(h_last_o),           128'(0));
        check("rst_h_data",  128'(h_data_o),           128'(0));
        check("rst_core_v",  128'(core_data_v_o),      128'(0));
        check("rst_ll",      128'(core_ll_o),          128'(0));
        check("rst_first",   128'(core_block_first_o), 128'(0));
        check("rst_last",    128'(core_block_last_o),  128'(0));
        check("rst_kk",      128'(core_kk_o),          128'(0));
        check("rst_nn",      128'(core_nn_o),          128'(0));

        mon_en    = 1'b1;
        core_auto = 1'b1;
        send_msg(3, 0, 64, 0, 1'b1, 1'b0, 1'b1);        wait_idle();
        send_msg(128, 0, 64, 0, 1'b0, 1'b0, 1'b1);      wait_idle();
        send_msg(129, 0, 64, 0, 1'b0, 1'b0, 1'b1);      wait_idle();
        send_msg(BB + 5, 32, 48, 10, 1'b0, 1'b0, 1'b1); wait_idle();
        send_msg(50, 0, 32, 40, 1'b0, 1'b1, 1'b1);      wait_idle();
        send_msg(256, 0, 1, 25, 1'b0, 1'b1, 1'b1);      wait_idle();
        for (int k = 0; k < 6; k++) begin
            send_msg(int'($urandom_range(1, 300)), int'($urandom_range(0, 64)),
                     int'($urandom_range(1, 64)), int'($urandom_range(0, 50)),
                     1'b0, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
        end

        // reset while padding
        mon_en    = 1'b0;
        core_auto = 1'b0;
        send_msg(3, 0, 64, 0, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (!(core_data_v_o && !s_ready_o) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("pad_not_reached");
        @(posedge clk); #1 nreset = 1'b0;
        @(posedge clk); #1 nreset = 1'b1;
        @(negedge clk);
        check("pad_rst_s_ready", 128'(s_ready_o),     128'(1));
        check("pad_rst_busy",    128'(busy_o),        128'(0));
        check("pad_rst_h_valid", 128'(h_valid_o),     128'(0));
        check("pad_rst_ll",      128'(core_ll_o),     128'(0));
        check("pad_rst_core_v",  128'(core_data_v_o), 128'(0));

        // reset while the digest is streaming out
        mon_en    = 1'b1;
        core_auto = 1'b1;
        send_msg(5, 0, 64, 0, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (!h_valid_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!h_valid_o) fail_now("out_not_reached");
        mon_en = 1'b0;
        @(posedge clk); #1 nreset = 1'b0;
        @(posedge clk); #1 nreset = 1'b1;
        @(negedge clk);
        check("out_rst_s_ready", 128'(s_ready_o), 128'(1));
        check("out_rst_busy",    128'(busy_o),    128'(0));
        check("out_rst_h_valid", 128'(h_valid_o), 128'(0));
        check("out_rst_ll",      128'(core_ll_o), 128'(0));
        seen = 1'b0;
        t = 0;
        while (core_busy && t < 500) begin
            @(negedge clk);
            if (h_valid_o) seen = 1'b1;
            t++;
        end
        check("out_rst_no_partial_digest", 128'(seen), 128'(0));
        h_q.delete();
        core_q.delete();
        dn_q.delete();
        db_q.delete();
        mon_en = 1'b1;

        send_msg(3, 0, 64, 20, 1'b0, 1'b0, 1'b1);   wait_idle();
        send_msg(129, 0, 16, 20, 1'b0, 1'b0, 1'b1); wait_idle();
`ifdef BLAKE2_SCHED_STATS_EN
        check("stat_blocks", 128'(stat_blocks_o), 128'(3));
        check("stat_msgs",   128'(stat_msgs_o),   128'(2));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
